// File: rtl/uart_axi_slave_regs_if.sv
// AXI4 channel bundle between the bus master and the UART register slave.
// Only the low three address bits are carried; the slave decodes nothing above them.
interface uart_axi_slave_regs_if;
  logic [2:0]  AW_add;
  logic [7:0]  AW_len;
  logic [1:0]  AW_burst;
  logic        AW_valid;
  logic        AW_ready;
  logic [31:0] W_data;
  logic [3:0]  W_strb;
  logic        W_last;
  logic        W_valid;
  logic        W_ready;
  logic [1:0]  B_response;
  logic        B_valid;
  logic        B_ready;
  logic        B_id;
  logic        B_user;
  logic [2:0]  AR_add;
  logic [7:0]  AR_len;
  logic [1:0]  AR_burst;
  logic        AR_valid;
  logic        AR_ready;
  logic [31:0] R_data;
  logic [1:0]  R_resp;
  logic        R_valid;
  logic        R_last;
  logic        R_ready;
  logic        R_id;
  logic        R_user;

  modport master (
    output AW_add, AW_len, AW_burst, AW_valid, W_data, W_strb, W_last, W_valid, B_ready,
           AR_add, AR_len, AR_burst, AR_valid, R_ready,
    input  AW_ready, W_ready, B_response, B_valid, B_id, B_user,
           AR_ready, R_data, R_resp, R_valid, R_last, R_id, R_user
  );

  modport slave (
    input  AW_add, AW_len, AW_burst, AW_valid, W_data, W_strb, W_last, W_valid, B_ready,
           AR_add, AR_len, AR_burst, AR_valid, R_ready,
    output AW_ready, W_ready, B_response, B_valid, B_id, B_user,
           AR_ready, R_data, R_resp, R_valid, R_last, R_id, R_user
  );
endinterface

// File: rtl/uart_axi_slave_regs.sv
// AXI4 slave front end of the UART: maps write/read bursts onto COM_CONFIG, the TX/RX FIFOs
// and the IRQ pending register. Write and read FSMs run independently.
module uart_axi_slave_regs (
  input  logic                        clk,
  input  logic                        rst,
  uart_axi_slave_regs_if.slave        bus,
  output logic                        tx_wr_en,
  output logic [7:0]                  tx_wr_data,
  input  logic                        tx_full,
  input  logic                        tx_empty,
  output logic                        rx_rd_en,
  input  logic [7:0]                  rx_rd_data,
  input  logic                        rx_full,
  input  logic                        rx_empty,
  input  logic                        rx_irq_set,
  input  logic                        tx_irq_set,
  output logic [31:0]                 cfg,
  output logic                        irq
);

  localparam logic [2:0] AddrComConfig = 3'd0;
  localparam logic [2:0] AddrFifoTx    = 3'd1;
  localparam logic [2:0] AddrFifoRx    = 3'd2;
  localparam logic [2:0] AddrIrq       = 3'd3;
  localparam logic [2:0] AddrRxData    = 3'd4;
  localparam logic [1:0] BurstFixed    = 2'b00;
  localparam logic [1:0] BurstIncr     = 2'b01;
  localparam logic [1:0] RespSlvErr    = 2'b10;

  typedef enum logic [1:0] {WRst, WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RRst, RIdle, RData, RBubble} r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic [2:0]  waddr_q, raddr_q;
  logic [1:0]  wburst_q, rburst_q;
  logic        werr_q;
  logic [7:0]  rrem_q;
  logic [23:0] cfg_q;
  logic [1:0]  pend_q, pend_d;
  logic        wbeat, w_ok, cfg_wr, irq_wr, tx_push, beat_err;
  logic        rbeat, r_ok, pop, rerr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{bus.AW_len, bus.W_strb[3]};
  assign bus.B_id    = 1'b0;
  assign bus.B_user  = 1'b0;
  assign bus.R_id    = 1'b0;
  assign bus.R_user  = 1'b0;
  assign cfg         = {8'h00, cfg_q};
  assign irq         = |pend_q;

  // Write side: decode of the current beat and FSM.
  always_comb begin
    w_state_d      = w_state_q;
    bus.AW_ready   = (w_state_q == WIdle);
    bus.W_ready    = (w_state_q == WData);
    bus.B_valid    = (w_state_q == WResp);
    bus.B_response = (bus.B_valid && werr_q) ? RespSlvErr : 2'b00;
    wbeat          = bus.W_valid && bus.W_ready;
    w_ok           = (wburst_q == BurstFixed) || (wburst_q == BurstIncr);
    cfg_wr         = wbeat && w_ok && (waddr_q == AddrComConfig);
    irq_wr         = wbeat && w_ok && (waddr_q == AddrIrq);
    tx_push        = wbeat && w_ok && (waddr_q == AddrFifoTx) && bus.W_strb[0] && !tx_full;
    beat_err       = wbeat && (!w_ok || (waddr_q > AddrRxData) ||
                     ((waddr_q == AddrFifoTx) && bus.W_strb[0] && tx_full));
    unique case (w_state_q)
      WRst:  w_state_d = WIdle;
      WIdle: if (bus.AW_valid) w_state_d = WData;
      WData: if (wbeat && bus.W_last) w_state_d = WResp;
      WResp: if (bus.B_ready) w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= WRst;
      waddr_q    <= 3'd0;
      wburst_q   <= 2'b00;
      werr_q     <= 1'b0;
      tx_wr_en   <= 1'b0;
      tx_wr_data <= 8'h00;
    end else begin
      w_state_q <= w_state_d;
      tx_wr_en  <= tx_push;
      if (tx_push) tx_wr_data <= bus.W_data[7:0];
      if (bus.AW_valid && bus.AW_ready) begin
        waddr_q  <= bus.AW_add;
        wburst_q <= bus.AW_burst;
        werr_q   <= 1'b0;
      end else if (wbeat) begin
        if (wburst_q == BurstIncr) waddr_q <= waddr_q + 3'd1;
        werr_q <= werr_q | beat_err;
      end
    end
  end

  // An enabled core event wins over a same-cycle software write of the pending bits.
  always_comb begin
    pend_d = pend_q;
    if (irq_wr) pend_d = bus.W_data[1:0];
    if (rx_irq_set && cfg_q[22]) pend_d[0] = 1'b1;
    if (tx_irq_set && cfg_q[23]) pend_d[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q  <= 24'h08_0145;
      pend_q <= 2'b00;
    end else begin
      pend_q <= pend_d;
      if (cfg_wr && bus.W_strb[0]) cfg_q[7:0]   <= bus.W_data[7:0];
      if (cfg_wr && bus.W_strb[1]) cfg_q[15:8]  <= bus.W_data[15:8];
      if (cfg_wr && bus.W_strb[2]) cfg_q[23:16] <= bus.W_data[23:16];
    end
  end

  // Read side: data/response are combinational from the current beat address.
  always_comb begin
    r_state_d    = r_state_q;
    bus.AR_ready = (r_state_q == RIdle);
    bus.R_valid  = (r_state_q == RData);
    bus.R_last   = bus.R_valid && (rrem_q == 8'd0);
    rbeat        = bus.R_valid && bus.R_ready;
    r_ok         = (rburst_q == BurstFixed) || (rburst_q == BurstIncr);
    rdata        = 32'h0;
    rerr         = 1'b0;
    unique case (raddr_q)
      AddrComConfig: rdata = cfg;
      AddrFifoTx:    rdata = {30'h0, tx_empty, tx_full};
      AddrFifoRx:    rdata = {16'h0, rx_rd_data, 6'h0, rx_empty, rx_full};
      AddrIrq:       rdata = {30'h0, pend_q};
      AddrRxData: begin
        rdata = {24'h0, rx_rd_data};
        rerr  = rx_empty;
      end
      default:       rerr  = 1'b1;
    endcase
    if (!r_ok) begin
      rdata = 32'h0;
      rerr  = 1'b1;
    end
    bus.R_data = bus.R_valid ? rdata : 32'h0;
    bus.R_resp = (bus.R_valid && rerr) ? RespSlvErr : 2'b00;
    pop        = rbeat && r_ok && (raddr_q == AddrRxData) && !rx_empty;
    unique case (r_state_q)
      RRst:    r_state_d = RIdle;
      RIdle:   if (bus.AR_valid) r_state_d = RData;
      RData: begin
        if (rbeat) begin
          if (rrem_q == 8'd0) r_state_d = RIdle;
          else if (pop && (rburst_q == BurstFixed)) r_state_d = RBubble;
        end
      end
      RBubble: r_state_d = RData;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RRst;
      raddr_q   <= 3'd0;
      rburst_q  <= 2'b00;
      rrem_q    <= 8'd0;
      rx_rd_en  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rx_rd_en  <= pop;
      if (bus.AR_valid && bus.AR_ready) begin
        raddr_q  <= bus.AR_add;
        rburst_q <= bus.AR_burst;
        rrem_q   <= (bus.AR_len == 8'd0) ? 8'd0 : bus.AR_len - 8'd1;
      end else if (rbeat && (rrem_q != 8'd0)) begin
        rrem_q <= rrem_q - 8'd1;
        if (rburst_q == BurstIncr) raddr_q <= raddr_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_axi_slave_regs.sv
// Directed bench for uart_axi_slave_regs with small TX/RX FIFO stand-ins.
module tb_uart_axi_slave_regs;
  logic        clk;
  logic        rst;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_rd_en;
  logic [7:0]  rx_rd_data;
  logic        rx_empty;
  logic        rx_irq_set;
  logic        tx_irq_set;
  logic [31:0] cfg;
  logic        irq;

  uart_axi_slave_regs_if bus ();

  uart_axi_slave_regs dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .tx_wr_en   (tx_wr_en),
    .tx_wr_data (tx_wr_data),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .rx_rd_en   (rx_rd_en),
    .rx_rd_data (rx_rd_data),
    .rx_full    (1'b0),
    .rx_empty   (rx_empty),
    .rx_irq_set (rx_irq_set),
    .tx_irq_set (tx_irq_set),
    .cfg        (cfg),
    .irq        (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // TX FIFO stand-in: full once tx_limit pushes (including the one in flight) are reached.
  int         tx_cnt = 0;
  int         tx_limit = 1000;
  logic [7:0] tx_last = 8'h00;
  // RX FIFO stand-in: entries rx_mem[rx_rd .. rx_wr-1], show-ahead head.
  logic [7:0] rx_mem [4];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         rx_pops = 0;

  assign tx_full    = (tx_cnt + (tx_wr_en ? 1 : 0)) >= tx_limit;
  assign rx_empty   = (rx_rd == rx_wr);
  assign rx_rd_data = rx_mem[rx_rd % 4];

  always @(posedge clk) begin
    if (tx_wr_en) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_wr_data;
    end
    if (rx_rd_en) begin
      rx_pops <= rx_pops + 1;
      if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  int          tx_irq_beat = -1;
  logic [31:0] rd [8];
  logic [1:0]  rr [8];
  logic        rl [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [2:0] addr, input logic [1:0] burst, input int nbeats,
                           output logic [1:0] resp, output int lat);
    int t;
    bus.AW_add   = addr;
    bus.AW_len   = 8'(nbeats);
    bus.AW_burst = burst;
    bus.AW_valid = 1'b1;
    t = 0;
    while (!bus.AW_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.AW_ready) check_eq("aw_ready_wait", {31'h0, bus.AW_ready}, 32'd1);
    @(posedge clk); #1;
    bus.AW_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.W_data  = wd[i];
      bus.W_strb  = ws[i];
      bus.W_last  = (i == nbeats - 1);
      bus.W_valid = 1'b1;
      t = 0;
      while (!bus.W_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!bus.W_ready) check_eq("w_ready_wait", {31'h0, bus.W_ready}, 32'd1);
      if (i == tx_irq_beat) tx_irq_set = 1'b1;
      @(posedge clk); #1;
      tx_irq_set = 1'b0;
    end
    bus.W_valid = 1'b0;
    bus.W_last  = 1'b0;
    bus.B_ready = 1'b1;
    lat = 0;
    while (!bus.B_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.B_valid) check_eq("b_valid_wait", {31'h0, bus.B_valid}, 32'd1);
    resp = bus.B_response;
    @(posedge clk); #1;
    bus.B_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [2:0] addr, input logic [1:0] burst, input int nbeats);
    int t;
    bus.AR_add   = addr;
    bus.AR_len   = 8'(nbeats);
    bus.AR_burst = burst;
    bus.AR_valid = 1'b1;
    t = 0;
    while (!bus.AR_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.AR_ready) check_eq("ar_ready_wait", {31'h0, bus.AR_ready}, 32'd1);
    @(posedge clk); #1;
    bus.AR_valid = 1'b0;
    bus.R_ready  = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      t = 0;
      while (!bus.R_valid && t < 50) begin @(posedge clk); #1; t++; end
      if (!bus.R_valid) check_eq("r_valid_wait", {31'h0, bus.R_valid}, 32'd1);
      rd[i] = bus.R_data;
      rr[i] = bus.R_resp;
      rl[i] = bus.R_last;
      @(posedge clk); #1;
    end
    bus.R_ready = 1'b0;
  endtask

  logic [1:0] resp;
  int         lat;
  int         base;

  initial begin
    rst = 1'b1;
    tx_empty = 1'b1;
    rx_irq_set = 1'b0;
    tx_irq_set = 1'b0;
    bus.AW_add = 3'd0; bus.AW_len = 8'd0; bus.AW_burst = 2'b00; bus.AW_valid = 1'b0;
    bus.W_data = 32'h0; bus.W_strb = 4'h0; bus.W_last = 1'b0; bus.W_valid = 1'b0;
    bus.B_ready = 1'b0;
    bus.AR_add = 3'd0; bus.AR_len = 8'd0; bus.AR_burst = 2'b00; bus.AR_valid = 1'b0;
    bus.R_ready = 1'b0;
    for (int i = 0; i < 4; i++) rx_mem[i] = 8'h00;

    // Reset values and first-edge AW/AR ready.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cfg", cfg, 32'h0008_0145);
    check_eq("rst_hs", {bus.AW_ready, bus.W_ready, bus.B_valid, bus.AR_ready, bus.R_valid,
                        bus.R_last, tx_wr_en, rx_rd_en, irq}, 32'h0);
    check_eq("rst_data", {bus.B_response, bus.R_resp, bus.R_data[27:0]}, 32'h0);
    rst = 1'b0;
    check_eq("aw_ready_before_edge", {31'h0, bus.AW_ready}, 32'd0);
    @(posedge clk); #1;
    check_eq("ready_after_rst", {30'h0, bus.AW_ready, bus.AR_ready}, 32'd3);

    // Single CONFIG write then readback.
    wd[0] = 32'h0008_00A3; ws[0] = 4'hF;
    axi_write(3'd0, 2'b00, 1, resp, lat);
    check_eq("cfg_wr_resp", {30'h0, resp}, 32'd0);
    check_eq("cfg_wr_b_latency", {31'h0, lat <= 3}, 32'd1);
    axi_read(3'd0, 2'b00, 1);
    check_eq("cfg_rd_data", rd[0], 32'h0008_00A3);
    check_eq("cfg_rd_last_resp", {29'h0, rl[0], rr[0]}, {29'h0, 1'b1, 2'b00});

    // INCR 4-beat burst from 0: CONFIG low half, TX push, FIFO_RX ignored, IRQ write.
    base = tx_cnt;
    wd[0] = 32'hFFFF_1234; ws[0] = 4'h3;
    wd[1] = 32'h0000_005A; ws[1] = 4'h1;
    wd[2] = 32'hDEAD_BEEF; ws[2] = 4'hF;
    wd[3] = 32'h0000_0001; ws[3] = 4'hF;
    axi_write(3'd0, 2'b01, 4, resp, lat);
    check_eq("incr_resp", {30'h0, resp}, 32'd0);
    check_eq("incr_cfg", cfg, 32'h0008_1234);
    check_eq("incr_push_cnt", tx_cnt - base, 32'd1);
    check_eq("incr_push_byte", {24'h0, tx_last}, 32'h5A);
    check_eq("incr_irq", {31'h0, irq}, 32'd1);

    // FIXED 4-beat to FIFO_TX; FIFO fills after two pushes.
    base = tx_cnt;
    tx_limit = base + 2;
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'h1;
    axi_write(3'd1, 2'b00, 4, resp, lat);
    @(posedge clk); #1;
    check_eq("txfull_pushes", tx_cnt - base, 32'd2);
    check_eq("txfull_last_byte", {24'h0, tx_last}, 32'h22);
    check_eq("txfull_resp", {30'h0, resp}, 32'd2);
    tx_limit = 1000;

    // Write to reserved address errors; WRAP burst errors with no CONFIG change.
    wd[0] = 32'h0; ws[0] = 4'hF;
    axi_write(3'd6, 2'b00, 1, resp, lat);
    check_eq("wr_addr6_resp", {30'h0, resp}, 32'd2);
    wd[0] = 32'h0000_7777; ws[0] = 4'hF;
    axi_write(3'd0, 2'b10, 1, resp, lat);
    check_eq("wrap_resp", {30'h0, resp}, 32'd2);
    check_eq("wrap_no_effect", cfg, 32'h0008_1234);

    // RX FIFO reads.
    rx_mem[0] = 8'h55; rx_mem[1] = 8'hAA; rx_wr = 2;
    base = rx_pops;
    axi_read(3'd2, 2'b00, 1);
    check_eq("rx_status", rd[0], 32'h0000_5500);
    axi_read(3'd4, 2'b00, 2);
    @(posedge clk); #1;
    check_eq("rx_beat0", rd[0], 32'h55);
    check_eq("rx_beat1", rd[1], 32'hAA);
    check_eq("rx_last_flags", {30'h0, rl[0], rl[1]}, 32'd1);
    check_eq("rx_resps", {28'h0, rr[0], rr[1]}, 32'd0);
    check_eq("rx_pops", rx_pops - base, 32'd2);
    axi_read(3'd4, 2'b00, 1);
    @(posedge clk); #1;
    check_eq("rx_empty_resp", {30'h0, rr[0]}, 32'd2);
    check_eq("rx_empty_no_pop", rx_pops - base, 32'd2);
    axi_read(3'd6, 2'b00, 1);
    check_eq("rd_addr6", {rr[0], rd[0][29:0]}, {2'b10, 30'h0});
    axi_read(3'd1, 2'b00, 1);
    check_eq("tx_status", rd[0], 32'd2);

    // IRQ: clear, disabled event ignored, enabled event sets, event beats write of 0.
    wd[0] = 32'h0; ws[0] = 4'hF;
    axi_write(3'd3, 2'b00, 1, resp, lat);
    check_eq("irq_cleared", {31'h0, irq}, 32'd0);
    rx_irq_set = 1'b1; @(posedge clk); #1; rx_irq_set = 1'b0; @(posedge clk); #1;
    check_eq("irq_disabled", {31'h0, irq}, 32'd0);
    wd[0] = 32'h00C8_0145; ws[0] = 4'hF;
    axi_write(3'd0, 2'b00, 1, resp, lat);
    check_eq("cfg_irq_en", cfg, 32'h00C8_0145);
    rx_irq_set = 1'b1; @(posedge clk); #1; rx_irq_set = 1'b0;
    check_eq("irq_rx_set", {31'h0, irq}, 32'd1);
    wd[0] = 32'h0; ws[0] = 4'hF;
    tx_irq_beat = 0;
    axi_write(3'd3, 2'b00, 1, resp, lat);
    tx_irq_beat = -1;
    check_eq("irq_set_wins", {31'h0, irq}, 32'd1);
    axi_read(3'd3, 2'b00, 1);
    check_eq("irq_pending", rd[0], 32'd2);

    // Reset in the middle of a write burst.
    bus.AW_add = 3'd0; bus.AW_len = 8'd2; bus.AW_burst = 2'b00; bus.AW_valid = 1'b1;
    @(posedge clk); #1;
    bus.AW_valid = 1'b0;
    bus.W_data = 32'h1111_1111; bus.W_strb = 4'hF; bus.W_last = 1'b0; bus.W_valid = 1'b1;
    @(posedge clk); #1;
    bus.W_valid = 1'b0;
    check_eq("mid_cfg", cfg, 32'h0011_1111);
    check_eq("mid_w_ready", {31'h0, bus.W_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_cfg", cfg, 32'h0008_0145);
    check_eq("mid_rst_hs", {bus.AW_ready, bus.W_ready, bus.B_valid, bus.AR_ready, bus.R_valid,
                            tx_wr_en, rx_rd_en, irq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_aw_ready", {30'h0, bus.AW_ready, bus.B_valid}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
